// File: rtl/act_ctrl_pkg.sv
// Shared definitions for the activation load/read sequencer: FSM encoding,
// activation width, default array size and an address-width helper.
package act_ctrl_pkg;

  localparam int ACT_W        = 7;
  localparam int DEFAULT_SIZE = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_READ = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // A depth of one still needs a 1-bit address bus.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/activation_load_ctrl.sv
// Activation memory write/read sequencer: loads MEM_SIZE streamed beats, then issues SIZE row reads.
// Define ACT_LOAD_TRANSPOSE_EN for a column-major input stream (write address transposed).
module activation_load_ctrl
  import act_ctrl_pkg::*;
#(
  parameter int SIZE             = DEFAULT_SIZE,
  parameter int MEM_SIZE         = SIZE * SIZE,
  parameter int WRITE_ADDR_WIDTH = addr_w(MEM_SIZE),
  parameter int READ_ADDR_WIDTH  = addr_w(SIZE)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [ACT_W-1:0]            act_in,
  input  logic                        act_valid,
  output logic                        act_ready,
  input  logic                        rd_stall,
  output logic [ACT_W-1:0]            Activation,
  output logic [WRITE_ADDR_WIDTH-1:0] Wr_Addr,
  output logic                        Wr_en,
  output logic                        Rd_en,
  output logic [READ_ADDR_WIDTH-1:0]  Rd_Addr,
  output logic                        out_valid,
  output logic                        busy,
  output logic                        done
);

  logic [1:0]                  r_state;
  logic [WRITE_ADDR_WIDTH-1:0] r_wcnt;
  logic [READ_ADDR_WIDTH-1:0]  r_rcnt;
  logic [ACT_W-1:0]            r_activation;
  logic [WRITE_ADDR_WIDTH-1:0] r_wr_addr;
  logic                        r_wr_en;
  logic                        r_rd_en;
  logic [READ_ADDR_WIDTH-1:0]  r_rd_addr;
  logic                        r_out_valid;
  logic                        r_busy;
  logic                        r_done;

  logic                        w_accept;
  logic                        w_rd_issue;
  logic                        w_last_beat;
  logic                        w_last_row;
  logic [WRITE_ADDR_WIDTH-1:0] w_wr_addr_map;

  assign act_ready   = (r_state == ST_LOAD);
  assign w_accept    = act_valid & act_ready;
  assign w_rd_issue  = (r_state == ST_READ) & ~rd_stall;
  assign w_last_beat = w_accept & (r_wcnt == WRITE_ADDR_WIDTH'(MEM_SIZE - 1));
  assign w_last_row  = w_rd_issue & (r_rcnt == READ_ADDR_WIDTH'(SIZE - 1));

  // Stream-order to memory-address mapping for the current beat.
  always_comb begin
`ifdef ACT_LOAD_TRANSPOSE_EN
    w_wr_addr_map = WRITE_ADDR_WIDTH'((int'(r_wcnt) % SIZE) * SIZE + (int'(r_wcnt) / SIZE));
`else
    w_wr_addr_map = r_wcnt;
`endif
  end

  // Tile FSM and beat/row counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_wcnt  <= '0;
      r_rcnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_LOAD;
            r_wcnt  <= '0;
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            r_wcnt <= r_wcnt + WRITE_ADDR_WIDTH'(1);
          end
          // READ is entered while the last write is still in flight; the
          // registered read path then lands one cycle behind it.
          if (w_last_beat) begin
            r_state <= ST_READ;
            r_rcnt  <= '0;
          end
        end
        ST_READ: begin
          if (w_rd_issue) begin
            r_rcnt <= r_rcnt + READ_ADDR_WIDTH'(1);
          end
          if (w_last_row) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Memory write port: one registered write per accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_activation <= '0;
    end else if (w_accept) begin
      r_wr_en      <= 1'b1;
      r_wr_addr    <= w_wr_addr_map;
      r_activation <= act_in;
    end else begin
      r_wr_en      <= 1'b0;
    end
  end

  // Memory read port: one registered row read per unstalled READ cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
    end else if (w_rd_issue) begin
      r_rd_en   <= 1'b1;
      r_rd_addr <= r_rcnt;
    end else begin
      r_rd_en   <= 1'b0;
    end
  end

  // Status: out_valid tracks the memory's one-cycle read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_out_valid <= r_rd_en;
      r_busy      <= (r_state != ST_IDLE);
      r_done      <= (r_state == ST_DONE);
    end
  end

  assign Activation = r_activation;
  assign Wr_Addr    = r_wr_addr;
  assign Wr_en      = r_wr_en;
  assign Rd_en      = r_rd_en;
  assign Rd_Addr    = r_rd_addr;
  assign out_valid  = r_out_valid;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_activation_load_ctrl.sv
// Randomized self-checking bench for activation_load_ctrl against a transaction-count model.
// Honours ACT_LOAD_TRANSPOSE_EN for the expected write-address order.
module tb_activation_load_ctrl;

  localparam int SIZE = 8;
  localparam int MEM  = SIZE * SIZE;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [6:0] act_in = 7'd0;
  logic       act_valid = 1'b0;
  logic       rd_stall = 1'b0;
  logic       act_ready;
  logic [6:0] Activation;
  logic [5:0] Wr_Addr;
  logic       Wr_en;
  logic       Rd_en;
  logic [2:0] Rd_Addr;
  logic       out_valid;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  activation_load_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .act_in(act_in), .act_valid(act_valid),
    .act_ready(act_ready), .rd_stall(rd_stall), .Activation(Activation), .Wr_Addr(Wr_Addr),
    .Wr_en(Wr_en), .Rd_en(Rd_en), .Rd_Addr(Rd_Addr), .out_valid(out_valid), .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int map_addr(input int n);
`ifdef ACT_LOAD_TRANSPOSE_EN
    return (n % SIZE) * SIZE + n / SIZE;
`else
    return n;
`endif
  endfunction

  // Reference model: a tile is "beats accepted so far" and "rows issued so far".
  bit         m_in_tile;
  int         m_beats, m_reads;
  logic       m_wr_en, m_rd_en, m_out_valid, m_busy, m_done;
  logic [5:0] m_wr_addr;
  logic [6:0] m_act;
  logic [2:0] m_rd_addr;
  logic       m_loading, m_reading, m_finishing;

  assign m_loading   = m_in_tile && (m_beats < MEM);
  assign m_reading   = m_in_tile && (m_beats == MEM) && (m_reads < SIZE);
  assign m_finishing = m_in_tile && (m_reads == SIZE);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_in_tile <= 1'b0; m_beats <= 0; m_reads <= 0;
      m_wr_en <= 1'b0; m_rd_en <= 1'b0; m_out_valid <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0;
      m_wr_addr <= 6'd0; m_act <= 7'd0; m_rd_addr <= 3'd0;
    end else begin
      m_out_valid <= m_rd_en;
      m_done      <= m_finishing;
      m_busy      <= m_in_tile;
      if (m_loading && act_valid) begin
        m_wr_en   <= 1'b1;
        m_wr_addr <= 6'(map_addr(m_beats));
        m_act     <= act_in;
        m_beats   <= m_beats + 1;
      end else begin
        m_wr_en <= 1'b0;
      end
      if (m_reading && !rd_stall) begin
        m_rd_en   <= 1'b1;
        m_rd_addr <= 3'(m_reads);
        m_reads   <= m_reads + 1;
      end else begin
        m_rd_en <= 1'b0;
      end
      if (m_finishing) begin
        m_in_tile <= 1'b0;
      end else if (!m_in_tile && start) begin
        m_in_tile <= 1'b1; m_beats <= 0; m_reads <= 0;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("act_ready", act_ready, m_loading);
      check("wr_en", Wr_en, m_wr_en);
      check("rd_en", Rd_en, m_rd_en);
      check("out_valid", out_valid, m_out_valid);
      check("busy", busy, m_busy);
      check("done", done, m_done);
      if (m_wr_en) begin
        check("wr_addr", Wr_Addr, m_wr_addr);
        check("activation", Activation, m_act);
      end
      if (m_rd_en) check("rd_addr", Rd_Addr, m_rd_addr);
    end
  end

  logic [5:0] wr_q[$];
  logic [2:0] rd_q[$];

  task automatic check_all_zero(input string tag);
    check({tag, "_act_ready"}, act_ready, 0);
    check({tag, "_wr_en"}, Wr_en, 0);
    check({tag, "_wr_addr"}, Wr_Addr, 0);
    check({tag, "_activation"}, Activation, 0);
    check({tag, "_rd_en"}, Rd_en, 0);
    check({tag, "_rd_addr"}, Rd_Addr, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // vmode: 0 = valid always, 1 = valid toggles 1,0,1,0, 2 = random valid.
  task automatic run_tile(input int vmode, input int spct, input bit stall3, input bit noise,
                          input bit seq_data, output int lat, output int nwr, output int nov,
                          output int gap);
    int  idx = 0;
    bit  prev_acc;
    int  stall_left = 0;
    int  last_wr = -1;
    int  first_rd = -1;
    bit  seen_done = 1'b0;
    wr_q.delete(); rd_q.delete();
    lat = 0; nwr = 0; nov = 0;
    @(negedge clk);
    start     = 1'b1;
    act_valid = (vmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    act_in    = seq_data ? 7'd0 : 7'($urandom_range(0, 127));
    rd_stall  = 1'b0;
    prev_acc  = act_valid && act_ready;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      if (Wr_en) begin nwr++; wr_q.push_back(Wr_Addr); last_wr = k; end
      if (Rd_en) begin rd_q.push_back(Rd_Addr); if (first_rd < 0) first_rd = k; end
      if (out_valid) nov++;
      if (done) begin seen_done = 1'b1; lat = k - 1; break; end
      if (prev_acc) idx++;
      start = noise && ((k < 10 && $urandom_range(0, 1) == 1) || (Rd_en && Rd_Addr == 3'd7));
      case (vmode)
        0:       act_valid = 1'b1;
        1:       act_valid = (k % 2 == 0);
        default: act_valid = ($urandom_range(0, 99) < 55);
      endcase
      act_in = seq_data ? 7'(idx) : 7'($urandom_range(0, 127));
      if (stall3) begin
        if (Rd_en && Rd_Addr == 3'd2) stall_left = 3;
        rd_stall = (stall_left > 0);
        if (stall_left > 0) stall_left--;
      end else begin
        rd_stall = ($urandom_range(0, 99) < spct);
      end
      prev_acc = act_valid && act_ready;
    end
    start = 1'b0; act_valid = 1'b0; rd_stall = 1'b0;
    gap = first_rd - last_wr;
    check("tile_done_seen", seen_done, 1);
    if (seen_done) begin
      check("busy_at_done", busy, 1);
      @(negedge clk);
      check("busy_after_done", busy, 0);
    end
  endtask

  initial begin
    int lat, nwr, nov, gap;
    int cnt;
    bit ok;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: back-to-back row-major beats, data = beat index.
    run_tile(0, 0, 1'b0, 1'b0, 1'b1, lat, nwr, nov, gap);
    check("t1_latency", lat, 73);
    check("t1_wr_count", nwr, 64);
    check("t1_ov_count", nov, 8);
    if (wr_q.size() == 64) begin
`ifdef ACT_LOAD_TRANSPOSE_EN
      check("t1_wr_addr1", wr_q[1], 8);
      check("t1_wr_addr9", wr_q[9], 9);
      check("t1_wr_addr63", wr_q[63], 63);
`else
      check("t1_wr_addr1", wr_q[1], 1);
      check("t1_wr_addr9", wr_q[9], 9);
      check("t1_wr_addr63", wr_q[63], 63);
`endif
    end
    for (int i = 0; i < rd_q.size(); i++) check("t1_rd_order", rd_q[i], i);

    // 2: valid toggling, no stall.
    run_tile(1, 0, 1'b0, 1'b0, 1'b1, lat, nwr, nov, gap);
    check("t2_wr_count", nwr, 64);
    check("t2_wr_rd_gap", gap, 1);
    ok = (wr_q.size() == 64);
    for (int i = 0; i < wr_q.size(); i++) if (wr_q[i] != 6'(map_addr(i))) ok = 1'b0;
    check("t2_wr_addr_seq", ok, 1);

    // 3: three-cycle read stall after row 2.
    run_tile(0, 0, 1'b1, 1'b0, 1'b1, lat, nwr, nov, gap);
    check("t3_latency", lat, 76);
    check("t3_ov_count", nov, 8);
    if (rd_q.size() > 3) check("t3_resume_addr", rd_q[3], 3);

    // 4: start pulsed during LOAD and DONE.
    run_tile(0, 0, 1'b0, 1'b1, 1'b1, lat, nwr, nov, gap);
    check("t4_ov_count", nov, 8);
    check("t4_wr_count", nwr, 64);
    repeat (3) @(negedge clk);
    check("t4_stays_idle", busy, 0);

    // 5: reset after 20 beats, then a fresh tile.
    @(negedge clk);
    start = 1'b1; act_valid = 1'b1; act_in = 7'd5;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    for (int k = 0; k < 200 && cnt < 20; k++) begin
      @(negedge clk);
      if (Wr_en) cnt++;
    end
    check("t5_beats_before_reset", cnt, 20);
    #2 rst_n = 1'b0;
    act_valid = 1'b0;
    #1 check_all_zero("t5_async");
    @(negedge clk);
    check_all_zero("t5_held");
    rst_n = 1'b1;
    @(negedge clk);
    run_tile(0, 0, 1'b0, 1'b0, 1'b0, lat, nwr, nov, gap);
    check("t5_wr_count", nwr, 64);
    if (wr_q.size() > 0) check("t5_first_addr", wr_q[0], 0);

    // Random tiles: random valid, stalls, data and spurious starts.
    for (int t = 0; t < 6; t++) begin
      run_tile(2, $urandom_range(0, 60), 1'b0, 1'($urandom_range(0, 1)), 1'b0,
               lat, nwr, nov, gap);
      check("rnd_wr_count", nwr, 64);
      check("rnd_ov_count", nov, 8);
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
